// File: rtl/shift_sequencer.sv
// Multi-cycle 1-bit-per-clock shifter with start/busy/done handshake.
// Optional rotate support is enabled by defining SHIFT_ROTATE_EN.
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             arith,
  input  logic             rot,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               arith_q, arith_d;
  logic               rot_q, rot_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               carry_out_q, carry_out_d;

  logic [WIDTH-1:0]   step_w;
  logic               step_c;
  logic               rot_in;

`ifdef SHIFT_ROTATE_EN
  assign rot_in = rot;
`else
  // rot is kept on the port for a uniform interface but has no effect here.
  logic unused_rot;
  assign unused_rot = rot;
  assign rot_in     = 1'b0;
`endif

  // Single 1-bit step of the working register; rot takes priority over arith.
  always_comb begin
    step_w = work_q;
    step_c = 1'b0;
`ifdef SHIFT_ROTATE_EN
    if (rot_q) begin
      if (dir_q) begin
        step_c = work_q[0];
        step_w = {work_q[0], work_q[WIDTH-1:1]};
      end else begin
        step_c = work_q[WIDTH-1];
        step_w = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      end
    end else
`endif
    if (dir_q) begin
      step_c = work_q[0];
      step_w = {(arith_q & work_q[WIDTH-1]), work_q[WIDTH-1:1]};
    end else begin
      step_c = work_q[WIDTH-1];
      step_w = {work_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    arith_d     = arith_q;
    rot_d       = rot_q;
    data_out_d  = data_out_q;
    carry_out_d = carry_out_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          work_d  = data_in;
          carry_d = 1'b0;
          cnt_d   = amount;
          dir_d   = dir;
          arith_d = arith;
          rot_d   = rot_in;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          work_d  = step_w;
          carry_d = step_c;
          cnt_d   = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = StDone;
          data_out_d  = (cnt_q != '0) ? step_w : work_q;
          carry_out_d = (cnt_q != '0) ? step_c : carry_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      arith_q     <= 1'b0;
      rot_q       <= 1'b0;
      data_out_q  <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      arith_q     <= arith_d;
      rot_q       <= rot_d;
      data_out_q  <= data_out_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q == StShift);
  assign done      = (state_q == StDone);
  assign data_out  = data_out_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; inputs driven and outputs
// sampled on the falling edge.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir;
  logic       arith;
  logic       rot;
  logic [2:0] amount;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
  logic       carry_out;

  int tests_run    = 0;
  int tests_failed = 0;

  shift_sequencer #(
    .WIDTH(8),
    .CNT_W(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .arith    (arith),
    .rot      (rot),
    .amount   (amount),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input logic [7:0] d, input logic dr, input logic ar, input logic rt,
                        input logic [2:0] n, output int lat, output logic [7:0] q,
                        output logic c);
    data_in = d;
    dir     = dr;
    arith   = ar;
    rot     = rt;
    amount  = n;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    q     = 8'hxx;
    c     = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        q   = data_out;
        c   = carry_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, done, data_out, carry_out} !== 11'b0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b data_out=%h carry_out=%b, required all 0",
               busy, done, data_out, carry_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shift_left();
    int         lat;
    logic [7:0] q;
    logic       c;
    run_op(8'h01, 1'b0, 1'b0, 1'b0, 3'd3, lat, q, c);
    tests_run++;
    if (lat !== 3 || q !== 8'h08 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL left_n3: lat=%0d q=%h c=%b, required lat=3 q=08 c=0", lat, q, c);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h08) begin
      tests_failed++;
      $display("FAIL done_pulse: done=%b busy=%b data_out=%h, required 0 0 08",
               done, busy, data_out);
    end
  endtask

  task automatic test_shift_right();
    int         lat;
    logic [7:0] q;
    logic       c;
    run_op(8'h95, 1'b1, 1'b0, 1'b0, 3'd1, lat, q, c);
    tests_run++;
    if (lat !== 1 || q !== 8'h4A || c !== 1'b1) begin
      tests_failed++;
      $display("FAIL lsr_n1: lat=%0d q=%h c=%b, required lat=1 q=4a c=1", lat, q, c);
    end
    @(negedge clk);
    run_op(8'h95, 1'b1, 1'b1, 1'b0, 3'd2, lat, q, c);
    tests_run++;
    if (lat !== 2 || q !== 8'hE5 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL asr_n2: lat=%0d q=%h c=%b, required lat=2 q=e5 c=0", lat, q, c);
    end
    @(negedge clk);
    run_op(8'h95, 1'b0, 1'b1, 1'b0, 3'd1, lat, q, c);
    tests_run++;
    if (lat !== 1 || q !== 8'h2A || c !== 1'b1) begin
      tests_failed++;
      $display("FAIL left_arith_ignored: lat=%0d q=%h c=%b, required lat=1 q=2a c=1",
               lat, q, c);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int         dones = 0;
    int         lat   = -1;
    logic [7:0] q     = 8'h00;
    logic       c     = 1'b0;
    logic       held  = 1'b0;
    data_in = 8'hFF;
    dir     = 1'b0;
    arith   = 1'b0;
    rot     = 1'b0;
    amount  = 3'd7;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) begin
        start   = 1'b1;
        data_in = 8'h00;
        amount  = 3'd1;
        dir     = 1'b1;
      end
      if (k == 3) begin
        start = 1'b0;
        held  = busy && (data_out == 8'h2A);
      end
      if (done === 1'b1) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          q   = data_out;
          c   = carry_out;
        end
      end
    end
    tests_run++;
    if (dones !== 1 || lat !== 7) begin
      tests_failed++;
      $display("FAIL busy_ignore: dones=%0d lat=%0d, required dones=1 lat=7", dones, lat);
    end
    tests_run++;
    if (q !== 8'h80 || c !== 1'b1) begin
      tests_failed++;
      $display("FAIL left_n7: q=%h c=%b, required q=80 c=1", q, c);
    end
    tests_run++;
    if (held !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_while_busy: busy/held=%b, required 1 (old result 2a held)", held);
    end
  endtask

  task automatic test_rotate();
    int         lat;
    logic [7:0] q;
    logic       c;
    logic [7:0] exp_q;
`ifdef SHIFT_ROTATE_EN
    exp_q = 8'h03;
`else
    exp_q = 8'h02;
`endif
    run_op(8'h81, 1'b0, 1'b0, 1'b1, 3'd1, lat, q, c);
    tests_run++;
    if (lat !== 1 || q !== exp_q || c !== 1'b1) begin
      tests_failed++;
      $display("FAIL rot_left: lat=%0d q=%h c=%b, required lat=1 q=%h c=1", lat, q, c, exp_q);
    end
`ifdef SHIFT_ROTATE_EN
    @(negedge clk);
    run_op(8'h81, 1'b1, 1'b1, 1'b1, 3'd2, lat, q, c);
    tests_run++;
    if (lat !== 2 || q !== 8'h60 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL rot_right: lat=%0d q=%h c=%b, required lat=2 q=60 c=0", lat, q, c);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int         lat;
    logic [7:0] q;
    logic       c;
    run_op(8'h01, 1'b0, 1'b0, 1'b0, 3'd1, lat, q, c);
    tests_run++;
    if (lat !== 1 || q !== 8'h02 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: lat=%0d q=%h c=%b, required lat=1 q=02 c=0", lat, q, c);
    end
    // Issued in the done cycle, so it is accepted from DONE.
    run_op(8'h80, 1'b1, 1'b0, 1'b0, 3'd2, lat, q, c);
    tests_run++;
    if (lat !== 2 || q !== 8'h20 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: lat=%0d q=%h c=%b, required lat=2 q=20 c=0", lat, q, c);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_and_reset();
    int         lat;
    logic [7:0] q;
    logic       c;
    int         dones = 0;
    run_op(8'h5A, 1'b0, 1'b0, 1'b0, 3'd0, lat, q, c);
    tests_run++;
    if (lat !== 1 || q !== 8'h5A || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_amount: lat=%0d q=%h c=%b, required lat=1 q=5a c=0", lat, q, c);
    end
    @(negedge clk);
    data_in = 8'h5A;
    amount  = 3'd5;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({busy, done, data_out, carry_out} !== 11'b0) begin
      tests_failed++;
      $display("FAIL abort_reset: busy=%b done=%b data_out=%h carry_out=%b, required all 0",
               busy, done, data_out, carry_out);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: dones=%0d busy=%b, required 0 0", dones, busy);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    dir     = 1'b0;
    arith   = 1'b0;
    rot     = 1'b0;
    amount  = 3'd0;
    data_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_shift_left();
    test_shift_right();
    test_busy_ignore();
    test_rotate();
    test_back_to_back();
    test_zero_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
